// File: rtl/rtl_settings_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : rtl_settings_pkg
//  Description: CSR map constants and sequencer state encoding shared by the
//               mem_checker CSR test sequencer.
//  Revision   : 1.0  initial release
// ============================================================================
package rtl_settings_pkg;

  localparam logic [3:0] CSR_CTRL      = 4'd0;
  localparam logic [3:0] CSR_PARAM0    = 4'd1;
  localparam logic [3:0] CSR_STATUS    = 4'd4;
  localparam logic [3:0] CSR_RES_FIRST = 4'd5;
  localparam logic [3:0] CSR_RES_LAST  = 4'd14;
  localparam int         RES_WORDS     = 10;
  localparam int         PARAM_WORDS   = 3;

  typedef enum logic [3:0] {
    SEQ_IDLE      = 4'd0,
    SEQ_WR_PARAM  = 4'd1,
    SEQ_WR_START  = 4'd2,
    SEQ_POLL_WAIT = 4'd3,
    SEQ_POLL_RD   = 4'd4,
    SEQ_POLL_CHK  = 4'd5,
    SEQ_RD_RES    = 4'd6,
    SEQ_RES_LAST  = 4'd7,
    SEQ_FINISH    = 4'd8
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/csr_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module     : csr_test_sequencer
//  Description: Avalon-MM master that programs mem_checker, polls its status
//               and snapshots the ten result words.
//  Revision   : 1.0  initial release
// ============================================================================
module csr_test_sequencer
  import rtl_settings_pkg::*;
#(
  parameter int POLL_GAP   = 16,
  parameter int POLL_LIMIT = 4096,
  parameter int POLL_CNT_W = 13
) (
  input  logic                             clk_sys_i,
  input  logic                             rst_i,
  input  logic                             run_i,
  input  logic [PARAM_WORDS-1:0][31:0]     param_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             timeout_o,
  output logic [RES_WORDS-1:0][31:0]       result_o,
  output logic                             sys_read_o,
  output logic                             sys_write_o,
  output logic [3:0]                       sys_address_o,
  output logic [31:0]                      sys_writedata_o,
  input  logic [31:0]                      sys_readdata_i
);

  localparam int                    c_GAP_W     = $clog2(POLL_GAP + 1);
  localparam logic [c_GAP_W-1:0]    c_GAP_END   = c_GAP_W'(POLL_GAP - 1);
  localparam logic [POLL_CNT_W-1:0] c_POLL_MAX  = POLL_CNT_W'(POLL_LIMIT);
  localparam logic [3:0]            c_PARAM_END = 4'(PARAM_WORDS - 1);
  localparam logic [3:0]            c_RES_END   = 4'(RES_WORDS - 1);

  seq_state_e                   r_state;
  seq_state_e                   w_next;
  logic [PARAM_WORDS-1:0][31:0] r_param;
  logic [3:0]                   r_idx;
  logic [c_GAP_W-1:0]           r_gap_cnt;
  logic [POLL_CNT_W-1:0]        r_poll_cnt;
  logic                         r_timeout;
  logic                         r_cap_vld;
  logic [3:0]                   r_cap_idx;
  logic [RES_WORDS-1:0][31:0]   r_result;
  logic                         w_start;
  logic                         w_poll_expired;
  logic [31:0]                  w_param_sel;

  assign w_start        = (r_state == SEQ_IDLE) && run_i;
  assign w_poll_expired = (r_state == SEQ_POLL_CHK) && !sys_readdata_i[0]
                          && (r_poll_cnt == c_POLL_MAX);

  // State register
  always_ff @(posedge clk_sys_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      SEQ_IDLE:      if (run_i) w_next = SEQ_WR_PARAM;
      SEQ_WR_PARAM:  if (r_idx == c_PARAM_END) w_next = SEQ_WR_START;
      SEQ_WR_START:  w_next = SEQ_POLL_WAIT;
      SEQ_POLL_WAIT: if (r_gap_cnt == c_GAP_END) w_next = SEQ_POLL_RD;
      SEQ_POLL_RD:   w_next = SEQ_POLL_CHK;
      SEQ_POLL_CHK: begin
        if (sys_readdata_i[0])               w_next = SEQ_RD_RES;
        else if (r_poll_cnt == c_POLL_MAX)   w_next = SEQ_FINISH;
        else                                 w_next = SEQ_POLL_WAIT;
      end
      SEQ_RD_RES:    if (r_idx == c_RES_END) w_next = SEQ_RES_LAST;
      SEQ_RES_LAST:  w_next = SEQ_FINISH;
      SEQ_FINISH:    w_next = SEQ_IDLE;
      default:       w_next = SEQ_IDLE;
    endcase
  end

  // Sequencing counters, parameter latch and sticky timeout
  always_ff @(posedge clk_sys_i or negedge rst_i) begin
    if (!rst_i) begin
      r_param    <= '0;
      r_idx      <= '0;
      r_gap_cnt  <= '0;
      r_poll_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_start) begin
        r_param    <= param_i;
        r_poll_cnt <= '0;
        r_timeout  <= 1'b0;
      end
      if ((r_state == SEQ_WR_PARAM && r_idx != c_PARAM_END) || r_state == SEQ_RD_RES) begin
        r_idx <= r_idx + 4'd1;
      end else begin
        r_idx <= '0;
      end
      if (r_state == SEQ_POLL_WAIT) begin
        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
      end else begin
        r_gap_cnt <= '0;
      end
      if (r_state == SEQ_POLL_RD && r_poll_cnt != c_POLL_MAX) begin
        r_poll_cnt <= r_poll_cnt + POLL_CNT_W'(1);
      end
      if (w_poll_expired) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Read data trails the address by one cycle, so the capture index is delayed too
  always_ff @(posedge clk_sys_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
      r_result  <= '0;
    end else begin
      r_cap_vld <= (r_state == SEQ_RD_RES);
      r_cap_idx <= r_idx;
      for (int k = 0; k < RES_WORDS; k++) begin
        if (r_cap_vld && r_cap_idx == 4'(k)) begin
          r_result[k] <= sys_readdata_i;
        end
      end
    end
  end

  always_comb begin
    case (r_idx[1:0])
      2'd0:    w_param_sel = r_param[0];
      2'd1:    w_param_sel = r_param[1];
      default: w_param_sel = r_param[2];
    endcase
  end

  // Output logic: bus fields are zero whenever no transfer is issued
  always_comb begin
    sys_read_o      = 1'b0;
    sys_write_o     = 1'b0;
    sys_address_o   = '0;
    sys_writedata_o = '0;
    busy_o          = (r_state != SEQ_IDLE) && (r_state != SEQ_FINISH);
    done_o          = (r_state == SEQ_FINISH);
    case (r_state)
      SEQ_WR_PARAM: begin
        sys_write_o     = 1'b1;
        sys_address_o   = CSR_PARAM0 + r_idx;
        sys_writedata_o = w_param_sel;
      end
      SEQ_WR_START: begin
        sys_write_o     = 1'b1;
        sys_address_o   = CSR_CTRL;
        sys_writedata_o = 32'h1;
      end
      SEQ_POLL_RD: begin
        sys_read_o    = 1'b1;
        sys_address_o = CSR_STATUS;
      end
      SEQ_RD_RES: begin
        sys_read_o    = 1'b1;
        sys_address_o = CSR_RES_FIRST + r_idx;
      end
      default: begin
        sys_read_o = 1'b0;
      end
    endcase
  end

  assign timeout_o = r_timeout;
  assign result_o  = r_result;

endmodule
`default_nettype wire

// File: doc/csr_test_sequencer.md
Name: csr_test_sequencer

Overview:
- Autonomous Avalon-MM master that drives the system-side CSR port of mem_checker (sys_read/sys_write/sys_address/sys_writedata/sys_readdata) in the clk_sys domain.
- On a run pulse it writes the three test-parameter words and the start bit, then polls the status word until the test finishes or a poll budget expires.
- On completion it burst-reads the ten result words into a local snapshot and pulses done.
- Lets the checker run from a host or a self-test without software.

Parameters:
- POLL_GAP, 16, idle cycles between consecutive status reads (≥1).
- POLL_LIMIT, 4096, maximum status reads before declaring timeout (≥1).
- POLL_CNT_W, 13, width of the poll counter; must satisfy 2^POLL_CNT_W > POLL_LIMIT.

Ports:
- clk_sys_i  in  1  system clock; the only clock.
- rst_i  in  1  asynchronous, active-low reset.
- run_i  in  1  single-cycle start request.
- param_i  in  3x32  test parameter words, destined for CSR 1..3.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle completion pulse.
- timeout_o  out  1  sticky; last run ended by poll budget.
- result_o  out  10x32  snapshot of CSR 5..14; index 0 = CSR 5.
- sys_read_o  out  1  Avalon-MM read.
- sys_write_o  out  1  Avalon-MM write.
- sys_address_o  out  4  CSR word address.
- sys_writedata_o  out  32  write data.
- sys_readdata_i  in  32  read data, valid exactly 1 cycle after sys_read_o; no waitrequest.

Behaviour:
- Reset (rst_i low, async): all outputs 0, result_o 0, FSM in IDLE, counters 0. Reset mid-sequence aborts immediately; sys_read_o/sys_write_o drop asynchronously.
- CSR map:
  - 0: control; write bit0=1 starts the test.
  - 1..3: parameters.
  - 4: status; bit0 = test finished.
  - 5..14: results.
- FSM states: IDLE, WR_PARAM, WR_START, POLL_WAIT, POLL_RD, POLL_CHK, RD_RES, RES_LAST, FINISH.
- IDLE:
  - run_i=1: latch param_i, clear timeout_o, set busy_o, go WR_PARAM.
  - run_i while busy_o=1 is ignored; no queuing.
- WR_PARAM: three consecutive cycles, sys_write_o=1 with address 1,2,3 and data = latched param[0..2]. Then WR_START.
- WR_START: one cycle, address 0, data 32'h1. Then POLL_WAIT with gap counter cleared.
- POLL_WAIT: count POLL_GAP cycles, then POLL_RD.
- POLL_RD:
  - One cycle sys_read_o=1, address 4.
  - Increment the poll counter.
  - Go POLL_CHK.
- POLL_CHK (sample sys_readdata_i):
  - bit0=1: go RD_RES.
  - else if poll counter == POLL_LIMIT: set timeout_o and go FINISH; result_o is not updated.
  - else: go POLL_WAIT.
- RD_RES:
  - sys_read_o=1 for 10 consecutive cycles, addresses 5..14.
  - The read issued at cycle t is captured at t+1 into result_o[addr-5], using a one-cycle delayed index register.
  - After the address-14 read, go RES_LAST, which captures the final word.
- FINISH: done_o=1 for one cycle, busy_o cleared in the same cycle, return IDLE.
- Latency from run_i at cycle 0 with an immediately finished test:
  - writes at cycles 1–4;
  - poll read at 5+POLL_GAP;
  - result reads start at 7+POLL_GAP;
  - done_o at 18+POLL_GAP.
- Bus rules:
  - sys_read_o and sys_write_o are never high together.
  - sys_address_o and sys_writedata_o are 0 whenever neither is asserted.
- Poll counter saturates; there is no wrap. It is cleared at each run start.
- result_o holds its value between runs and is overwritten word-by-word only during RD_RES/RES_LAST.

Decomposition:
- Shared package (rtl_settings_pkg):
  - CSR address constants: CSR_CTRL=0, CSR_PARAM0=1, CSR_STATUS=4, CSR_RES_FIRST=5, CSR_RES_LAST=14, RES_WORDS=10.
  - Sequencer state enum type.
- No sub-module needed. The FSM, gap/poll counters and capture index live in one module.

Test Plan:
- Reset, then run_i with params 0xA1, 0xB2, 0xC3; slave reports finished on the first poll.
  - Required: writes (1,0xA1), (2,0xB2), (3,0xC3), (0,0x1) on cycles 1–4.
  - Required: a read of address 4 at cycle 21 (POLL_GAP=16).
  - Required: reads 5..14 return 0x100+addr; result_o[k] = 0x105+k.
  - Required: done_o at cycle 34.
- Status bit0 stays 0 for 3 polls, then 1.
  - Required: exactly 4 address-4 reads, spaced POLL_GAP+2 cycles apart.
  - Required: results captured, timeout_o=0.
- POLL_LIMIT=5, status never set.
  - Required: exactly 5 polls, then done_o with timeout_o=1.
  - Required: result_o unchanged from the previous run.
- run_i pulsed again during POLL_WAIT.
  - Required: ignored; only one write sequence appears on the bus.
- rst_i asserted during RD_RES after word 4.
  - Required: all outputs 0 immediately, including result_o.
  - Required: a fresh run afterwards completes normally.
- Bus monitor over all tests.
  - Required: read and write never both high.
  - Required: address and data are 0 when the bus is idle.
